i2s_tdm_rx: RTL

Parametrised serial-audio receiver that deserialises an I2S stereo or TDM multi-channel bit stream into parallel samples. It replaces the fixed 32-bit stereo I2S receiver, adding configurable sample width, slot width and channel count, a TDM frame-sync mode, channel-tagged output and framing-error reporting. It sits between the serial audio pins and the sample-processing datapath, taking one serial bit per qualified clock.

---
 rtl/i2s_tdm_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/i2s_tdm_rx.sv
// I2S / TDM serial audio receiver: deserialises one bit per in_valid cycle into
// channel-tagged, MSB-aligned parallel samples with framing-error reporting.
module i2s_tdm_rx #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned MODE     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              WS,
  input  logic              SD,
  output logic              out_valid,
  output logic [2:0]        out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_end,
  output logic              err
);
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned SLOT_CW = 4;
  localparam bit          IS_TDM  = (MODE != 0);

  localparam logic [CNT_W-1:0]   DATA_LIM  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]   SLOT_LAST = CNT_W'(SLOT_W - 1);
  localparam logic [SLOT_CW-1:0] CH_LAST   = SLOT_CW'(CHANNELS - 1);
  localparam logic [SLOT_CW-1:0] CH_DONE   = SLOT_CW'(CHANNELS);
  localparam logic [DATA_W-1:0]  MSB_ONE   = DATA_W'(1) << (DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SYNC, RECV} state_e;

  state_e               state_q, state_d;
  logic                 ws_q, ws_d;
  logic                 vld_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SLOT_CW-1:0]   slot_q, slot_d;
  logic [DATA_W-1:0]    sr_q, sr_d;
  logic                 out_valid_q, out_valid_d;
  logic [2:0]           out_ch_q, out_ch_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 frame_end_q, frame_end_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    bit_one;
  logic [DATA_W-1:0]    captured;
  logic                 early_sync;

  // Bits are dropped straight into their MSB-aligned position, so short words
  // come out already left-justified and zero-padded.
  always_comb begin
    state_d     = state_q;
    ws_d        = ws_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    sr_d        = sr_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    frame_end_d = 1'b0;
    err_d       = 1'b0;
    bit_one     = SD ? (MSB_ONE >> cnt_q) : '0;
    captured    = (cnt_q < DATA_LIM) ? (sr_q | bit_one) : sr_q;
    early_sync  = WS && (slot_q != CH_DONE) &&
                  !((slot_q == CH_LAST) && (cnt_q == SLOT_LAST));

    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          ws_d    = WS;
          cnt_d   = '0;
          slot_d  = '0;
          sr_d    = '0;
          state_d = IS_TDM ? SYNC : RECV;
        end
        SYNC: begin
          if (WS) begin
            state_d = RECV;
            cnt_d   = '0;
            slot_d  = '0;
            sr_d    = '0;
          end
        end
        RECV: begin
          if (!IS_TDM) begin
            if (WS != ws_q) begin
              out_valid_d = 1'b1;
              out_ch_d    = 3'(ws_q);
              out_data_d  = captured;
              frame_end_d = ws_q;
              ws_d        = WS;
              cnt_d       = '0;
              sr_d        = '0;
            end else begin
              sr_d = captured;
              if (cnt_q < DATA_LIM) cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (early_sync) begin
            // The premature sync bit doubles as the sync for a fresh frame.
            err_d  = 1'b1;
            cnt_d  = '0;
            slot_d = '0;
            sr_d   = '0;
          end else if (cnt_q == SLOT_LAST) begin
            if (slot_q != CH_DONE) begin
              out_valid_d = 1'b1;
              out_ch_d    = 3'(slot_q);
              out_data_d  = captured;
              frame_end_d = (slot_q == CH_LAST);
              slot_d      = slot_q + SLOT_CW'(1);
            end
            if (WS) slot_d = '0;
            cnt_d = '0;
            sr_d  = '0;
          end else if (WS) begin
            slot_d = '0;
            cnt_d  = '0;
            sr_d   = '0;
          end else begin
            sr_d  = captured;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (vld_q) begin
      // Stream ended: I2S flushes a partial word, TDM flags a broken frame.
      state_d = IDLE;
      cnt_d   = '0;
      slot_d  = '0;
      sr_d    = '0;
      if (state_q == RECV) begin
        if (!IS_TDM && (cnt_q != '0)) begin
          out_valid_d = 1'b1;
          out_ch_d    = 3'(ws_q);
          out_data_d  = sr_q;
          frame_end_d = ws_q;
        end else if (IS_TDM && (slot_q != CH_DONE)) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ws_q        <= 1'b0;
      vld_q       <= 1'b0;
      cnt_q       <= '0;
      slot_q      <= '0;
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      vld_q       <= in_valid;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      frame_end_q <= frame_end_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign frame_end = frame_end_q;
  assign err       = err_q;
endmodule
